// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU.
//   alu_op_e    : opcode encoding presented on alu_sel
//   alu_state_e : control FSM states of alu_seq
//   FLAG_*      : bit positions inside out_flags ({zero, carry, overflow})
//   ovf_addsub  : two's-complement overflow for a WIDTH-bit add or subtract
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_MUL  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } alu_state_e;

    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // sa/sb: operand sign bits, sr: result sign bit, is_sub: 1 for A-B
    function automatic logic ovf_addsub(input logic sa, input logic sb,
                                        input logic sr, input logic is_sub);
        if (is_sub)
            return (sa != sb) && (sr != sa);
        else
            return (sa == sb) && (sr != sa);
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier, one partial product per clock.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (aborts a multiply)
//   start        : load a/b and clear accumulator/counter
//   a, b         : WIDTH-bit multiplicand / multiplier, sampled on start
//   done         : high during the cycle of the last step
//   product      : accumulator after the current step; valid when done=1
// The final step is taken by the consumer in the same edge as done, so a
// multiply occupies exactly WIDTH cycles after start.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic                busy_q,   busy_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [2*WIDTH-1:0]  mcand_q,  mcand_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;
    logic [2*WIDTH-1:0]  acc_q,    acc_d;
    logic [2*WIDTH-1:0]  acc_next;

    always_comb begin
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
        done     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
        product  = acc_next;

        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;

        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (done)
                busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes and a multi-cycle multiply.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operation request handshake (a, b, alu_sel)
//   a, b                 : WIDTH-bit unsigned operands
//   alu_sel              : opcode (alu_pkg::alu_op_e)
//   out_valid / out_ready: result handshake
//   alu_out              : 2*WIDTH-bit result, held until the next result
//   out_flags            : {zero, carry, overflow}, only with ALU_FLAGS_EN
// Build option: define ALU_FLAGS_EN to add the out_flags port and its logic.
//
// state | meaning
// IDLE  | ready for an operation; non-MUL results are registered on accept
// MUL   | multiplier stepping, one partial product per cycle
// HOLD  | result presented, waiting for out_ready
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           alu_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   alu_out
`ifdef ALU_FLAGS_EN
    ,
    output logic [2:0]           out_flags
`endif
);

    alu_state_e          state_q,     state_d;
    logic                out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]  alu_out_q,   alu_out_d;

    logic                accept;
    logic                mul_start;
    logic                mul_done;
    logic [2*WIDTH-1:0]  mul_product;
    logic [WIDTH:0]      sum;
    logic [WIDTH:0]      diff;
    logic [2*WIDTH-1:0]  res;
    alu_op_e             op;

`ifdef ALU_FLAGS_EN
    logic [2:0]          flags_q, flags_d;
    logic [2:0]          res_flags;
`endif

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
`ifdef ALU_FLAGS_EN
    assign out_flags = flags_q;
`endif

    assign op        = alu_op_e'(alu_sel);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle result for everything except MUL
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        case (op)
            OP_ADD:  res = {{(WIDTH-1){1'b0}}, sum};
            OP_SUB:  res = {{(WIDTH-1){1'b0}}, diff};
            OP_AND:  res = {{WIDTH{1'b0}}, a & b};
            OP_OR:   res = {{WIDTH{1'b0}}, a | b};
            OP_XOR:  res = {{WIDTH{1'b0}}, a ^ b};
            default: res = '0;
        endcase
    end

`ifdef ALU_FLAGS_EN
    always_comb begin
        res_flags         = '0;
        res_flags[FLAG_Z] = (res == '0);
        if (op == OP_ADD) begin
            res_flags[FLAG_C] = sum[WIDTH];
            res_flags[FLAG_V] = ovf_addsub(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1], 1'b0);
        end else if (op == OP_SUB) begin
            res_flags[FLAG_C] = diff[WIDTH];
            res_flags[FLAG_V] = ovf_addsub(a[WIDTH-1], b[WIDTH-1], diff[WIDTH-1], 1'b1);
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        alu_out_d   = alu_out_q;
`ifdef ALU_FLAGS_EN
        flags_d     = flags_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op == OP_MUL) begin
                        state_d = MUL;
                    end else begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        alu_out_d   = res;
`ifdef ALU_FLAGS_EN
                        flags_d     = res_flags;
`endif
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    state_d     = HOLD;
                    out_valid_d = 1'b1;
                    alu_out_d   = mul_product;
`ifdef ALU_FLAGS_EN
                    flags_d         = '0;
                    flags_d[FLAG_Z] = (mul_product == '0);
                    flags_d[FLAG_V] = |mul_product[2*WIDTH-1:WIDTH];
`endif
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
`ifdef ALU_FLAGS_EN
            flags_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
`ifdef ALU_FLAGS_EN
            flags_q     <= flags_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=8). Flag checks are compiled in
// only when ALU_FLAGS_EN is defined.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  alu_sel;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] alu_out;
`ifdef ALU_FLAGS_EN
    logic [2:0]  out_flags;
`endif

    int checks = 0;
    int errors = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_sel   (alu_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out)
`ifdef ALU_FLAGS_EN
        ,
        .out_flags (out_flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation with out_ready high, measure latency and the
    // number of cycles in_ready stays low, then complete the handshake.
    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [7:0] av, input logic [7:0] bv,
                         input logic [15:0] exp_out, input logic [2:0] exp_fl,
                         input int exp_lat);
        int lat;
        int ir_low;
        chk({tag, "_rdy_before"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        alu_sel   = op;
        a         = av;
        b         = bv;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        alu_sel  = 3'b000;
        a        = 8'h00;
        b        = 8'h00;
        lat      = 1;
        ir_low   = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) ir_low++;
            tick();
            lat++;
        end
        if (!in_ready) ir_low++;
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_rdy_low"}, 32'(ir_low), 32'(exp_lat));
        chk({tag, "_out"}, 32'(alu_out), 32'(exp_out));
`ifdef ALU_FLAGS_EN
        chk({tag, "_flags"}, 32'(out_flags), 32'(exp_fl));
`else
        if (exp_fl === 3'bxxx) $display("unused flag value for %s", tag);
`endif
        tick();
        chk({tag, "_vld_after"}, 32'(out_valid), 32'd0);
        chk({tag, "_rdy_after"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_held"}, 32'(alu_out), 32'(exp_out));
    endtask

    initial begin
        int seen_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        alu_sel   = 3'b000;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(alu_out), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd0);
`ifdef ALU_FLAGS_EN
        chk("rst_flags", 32'(out_flags), 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("rst_rdy_rel", 32'(in_ready), 32'd1);

        // ADD with carry out of bit 7
        do_op("add", OP_ADD, 8'd200, 8'd100, 16'h012C, 3'b010, 1);
        // SUB with borrow, then SUB to zero
        do_op("sub_brw", OP_SUB, 8'd5, 8'd7, 16'h01FE, 3'b010, 1);
        do_op("sub_zero", OP_SUB, 8'd9, 8'd9, 16'h0000, 3'b100, 1);
        // Full-scale multiply
        do_op("mul_ff", OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 3'b001, 9);
        do_op("mul_small", OP_MUL, 8'd3, 8'd5, 16'h000F, 3'b000, 9);
        do_op("and", OP_AND, 8'hFF, 8'hFF, 16'h00FF, 3'b000, 1);
        do_op("or", OP_OR, 8'hA0, 8'h05, 16'h00A5, 3'b000, 1);

        // XOR with back-pressure; a held request is ignored until in_ready
        chk("xor_rdy", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        alu_sel   = OP_XOR;
        a         = 8'hF0;
        b         = 8'h3C;
        out_ready = 1'b0;
        tick();
        alu_sel = OP_ADD;
        a       = 8'd1;
        b       = 8'd1;
        chk("xor_vld", 32'(out_valid), 32'd1);
        chk("xor_out", 32'(alu_out), 32'h00CC);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("xor_hold_vld", 32'(out_valid), 32'd1);
            chk("xor_hold_out", 32'(alu_out), 32'h00CC);
            chk("xor_hold_rdy", 32'(in_ready), 32'd0);
`ifdef ALU_FLAGS_EN
            chk("xor_hold_flags", 32'(out_flags), 32'd0);
`endif
        end
        out_ready = 1'b1;
        tick();
        chk("xor_hs_vld", 32'(out_valid), 32'd0);
        chk("xor_hs_rdy", 32'(in_ready), 32'd1);
        chk("xor_hs_out", 32'(alu_out), 32'h00CC);
        tick();
        in_valid = 1'b0;
        chk("held_add_vld", 32'(out_valid), 32'd1);
        chk("held_add_out", 32'(alu_out), 32'h0002);
        tick();
        chk("held_add_done", 32'(out_valid), 32'd0);

        // MUL aborted by reset on its 4th cycle
        in_valid = 1'b1;
        alu_sel  = OP_MUL;
        a        = 8'd13;
        b        = 8'd11;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("abort_rdy_mul", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_rdy_rst", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_rdy", 32'(in_ready), 32'd1);
        chk("abort_vld", 32'(out_valid), 32'd0);
        chk("abort_out", 32'(alu_out), 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen_valid++;
            tick();
        end
        chk("abort_no_result", 32'(seen_valid), 32'd0);
        do_op("add_after", OP_ADD, 8'd1, 8'd1, 16'h0002, 3'b000, 1);

        // Reserved opcodes
        do_op("rsv6", OP_RSV6, 8'hFF, 8'hFF, 16'h0000, 3'b100, 1);
        do_op("and2", OP_AND, 8'h0F, 8'hFF, 16'h000F, 3'b000, 1);
        do_op("rsv7", OP_RSV7, 8'hFF, 8'hFF, 16'h0000, 3'b100, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
